// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the ownership state encoding, port indices and counter width.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_grant2.sv
// Combinational two-port grant decision: round-robin with a bounded burst.
// Grants are one-hot or zero; reset gating is applied by the caller.
module rr_grant2
    import dmem_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic             req0_i,
    input  logic             req1_i,
    input  state_e           state_i,
    input  logic [CNT_W-1:0] burst_cnt_i,
    input  logic             last_owner_i,
    output logic             gnt0_o,
    output logic             gnt1_o
);

    localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);

    always_comb begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
        if (req0_i && req1_i) begin
            case (state_i)
                ST_OWN0: gnt0_o = (burst_cnt_i < BMAX);
                ST_OWN1: gnt0_o = (burst_cnt_i >= BMAX);
                default: gnt0_o = (last_owner_i == PORT1);
            endcase
            gnt1_o = ~gnt0_o;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a 1024x32 data memory (combinational read,
// clocked write). Tracks burst ownership and returns registered read data.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Gnt0,
    output logic [DATA_W-1:0] RData0,
    output logic              RValid0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt1,
    output logic [DATA_W-1:0] RData1,
    output logic              RValid1,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemReadData
);

    localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt0_raw, gnt1_raw;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic             rvalid0_q, rvalid1_q;

    rr_grant2 #(.BURST_MAX(BURST_MAX)) u_grant (
        .req0_i      (Req0),
        .req1_i      (Req1),
        .state_i     (state_q),
        .burst_cnt_i (cnt_q),
        .last_owner_i(last_q),
        .gnt0_o      (gnt0_raw),
        .gnt1_o      (gnt1_raw)
    );

    // Gating by Reset_n keeps a write issued during reset from reaching memory.
    always_comb begin
        Gnt0         = Reset_n & gnt0_raw;
        Gnt1         = Reset_n & gnt1_raw;
        MemAddress   = Gnt1 ? Addr1 : Addr0;
        MemWriteData = Gnt1 ? WData1 : WData0;
        MemWrite     = (Gnt0 & We0) | (Gnt1 & We1);
        MemRead      = (Gnt0 & ~We0) | (Gnt1 & ~We1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (Gnt0) begin
            if (state_q == ST_OWN0) begin
                if (cnt_q < BMAX) cnt_d = cnt_q + 1'b1;
            end else begin
                state_d = ST_OWN0;
                cnt_d   = CNT_W'(1);
                last_d  = PORT0;
            end
        end else if (Gnt1) begin
            if (state_q == ST_OWN1) begin
                if (cnt_q < BMAX) cnt_d = cnt_q + 1'b1;
            end else begin
                state_d = ST_OWN1;
                cnt_d   = CNT_W'(1);
                last_d  = PORT1;
            end
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= PORT1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= Gnt0 & ~We0;
            rvalid1_q <= Gnt1 & ~We1;
            if (Gnt0 && !We0) rdata0_q <= MemReadData;
            if (Gnt1 && !We1) rdata1_q <= MemReadData;
        end
    end

    assign RData0  = rdata0_q;
    assign RData1  = rdata1_q;
    assign RValid0 = rvalid0_q;
    assign RValid1 = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 memory attached.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Req0, We0, Req1, We1;
    logic [9:0]  Addr0, Addr1;
    logic [31:0] WData0, WData1;
    logic        Gnt0, Gnt1, RValid0, RValid1;
    logic [31:0] RData0, RData1;
    logic [9:0]  MemAddress;
    logic [31:0] MemWriteData, MemReadData;
    logic        MemRead, MemWrite;

    logic [31:0] mem [1024];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .BURST_MAX(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
        .Gnt0(Gnt0), .RData0(RData0), .RValid0(RValid0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1),
        .Gnt1(Gnt1), .RData1(RData1), .RValid1(RValid1),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
    );

    assign MemReadData = mem[MemAddress];
    always @(posedge Clock) if (MemWrite) mem[MemAddress] <= MemWriteData;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 10; i++) mem[10'h3F0 + i] = 32'hA500_0000 + 32'(i);

        // Reset with both ports requesting writes
        Reset_n = 1'b0;
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 10'h001; WData0 = 32'h1111_1111;
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 10'h002; WData1 = 32'h2222_2222;
        #2;
        chk_bit("rst_gnt0", Gnt0, 1'b0);
        chk_bit("rst_gnt1", Gnt1, 1'b0);
        chk_bit("rst_memwrite", MemWrite, 1'b0);
        chk_bit("rst_memread", MemRead, 1'b0);
        tick();
        tick();
        chk_bit("rst_rvalid0", RValid0, 1'b0);
        chk_bit("rst_rvalid1", RValid1, 1'b0);
        chk_word("rst_rdata0", RData0, 32'h0);
        chk_word("rst_mem1", mem[1], 32'h0);

        // Release; both request reads -> 0,0,0,0,1,1,1,1,0,0
        Reset_n = 1'b1;
        We0 = 1'b0; We1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic e0;
            e0 = (i < 4) || (i >= 8);
            #1;
            chk_bit($sformatf("burst_gnt0_%0d", i), Gnt0, e0);
            chk_bit($sformatf("burst_gnt1_%0d", i), Gnt1, ~e0);
            tick();
            chk_bit($sformatf("burst_rv0_%0d", i), RValid0, e0);
            chk_bit($sformatf("burst_rv1_%0d", i), RValid1, ~e0);
        end

        // Port 0 write then read of 0x005
        Req1 = 1'b0;
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 10'h005; WData0 = 32'hDEAD_BEEF;
        #1;
        chk_bit("wr_gnt0", Gnt0, 1'b1);
        chk_bit("wr_memwrite", MemWrite, 1'b1);
        chk_word("wr_addr", {22'd0, MemAddress}, 32'h005);
        chk_word("wr_wdata", MemWriteData, 32'hDEAD_BEEF);
        tick();
        chk_bit("wr_no_rvalid", RValid0, 1'b0);
        We0 = 1'b0;
        #1;
        chk_bit("rd_gnt0", Gnt0, 1'b1);
        chk_bit("rd_memread", MemRead, 1'b1);
        tick();
        chk_bit("rd_rvalid0", RValid0, 1'b1);
        chk_word("rd_rdata0", RData0, 32'hDEAD_BEEF);
        Req0 = 1'b0; Addr0 = 10'h0AA; Addr1 = 10'h155;
        #1;
        chk_bit("idle_gnt0", Gnt0, 1'b0);
        chk_bit("idle_memread", MemRead, 1'b0);
        chk_word("idle_addr_port0", {22'd0, MemAddress}, 32'h0AA);
        tick();
        chk_bit("rd_pulse_end", RValid0, 1'b0);
        chk_word("rd_hold", RData0, 32'hDEAD_BEEF);

        // Solo burst on port 1, 10 reads
        for (int i = 0; i < 10; i++) begin
            Req1 = 1'b1; We1 = 1'b0; Addr1 = 10'h3F0 + 10'(i);
            #1;
            chk_bit($sformatf("solo_gnt1_%0d", i), Gnt1, 1'b1);
            tick();
            chk_bit($sformatf("solo_rv1_%0d", i), RValid1, 1'b1);
            chk_word($sformatf("solo_rd1_%0d", i), RData1, 32'hA500_0000 + 32'(i));
        end

        // Idle, then port 1 takes ownership, then same-address contention
        Req1 = 1'b0;
        #1;
        chk_bit("gap_gnt1", Gnt1, 1'b0);
        tick();
        chk_bit("gap_rv1", RValid1, 1'b0);
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 10'h3F0;
        tick();
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 10'h3FF; WData1 = 32'h1234_5678;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 10'h3FF;
        #1;
        chk_bit("cont_gnt1", Gnt1, 1'b1);
        chk_bit("cont_gnt0", Gnt0, 1'b0);
        chk_bit("cont_memwrite", MemWrite, 1'b1);
        chk_word("cont_addr", {22'd0, MemAddress}, 32'h3FF);
        tick();
        chk_bit("cont_rv0_lost", RValid0, 1'b0);
        Req1 = 1'b0;
        #1;
        chk_bit("cont_retry_gnt0", Gnt0, 1'b1);
        tick();
        chk_bit("cont_rv0", RValid0, 1'b1);
        chk_word("cont_rd0", RData0, 32'h1234_5678);

        // Reset mid-read, with a suppressed write from port 1
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 10'h005;
        #1;
        chk_bit("mr_gnt0", Gnt0, 1'b1);
        #1;
        Reset_n = 1'b0;
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 10'h005; WData1 = 32'h0000_0BAD;
        #1;
        chk_bit("mr_gnt0_gated", Gnt0, 1'b0);
        chk_bit("mr_gnt1_gated", Gnt1, 1'b0);
        chk_bit("mr_memwrite", MemWrite, 1'b0);
        chk_bit("mr_memread", MemRead, 1'b0);
        tick();
        chk_bit("mr_rv0", RValid0, 1'b0);
        chk_word("mr_rdata0", RData0, 32'h0);
        Reset_n = 1'b1;
        We1 = 1'b0; Addr1 = 10'h3F1;
        #1;
        chk_bit("post_gnt0", Gnt0, 1'b1);
        chk_bit("post_gnt1", Gnt1, 1'b0);
        tick();
        chk_bit("post_rv0", RValid0, 1'b1);
        chk_bit("post_rv1", RValid1, 1'b0);
        chk_word("post_rd0", RData0, 32'hDEAD_BEEF);
        Req0 = 1'b0; Req1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
